// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded-instruction inputs, pipeline control, forwarding sources
// and the operand/control outputs that feed the ALU and later stages.
interface id_ex_stage_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [REGW-1:0] id_rs1;
  logic [REGW-1:0] id_rs2;
  logic [REGW-1:0] id_rd;
  logic [3:0]      id_alu_control;
  logic            id_alu_src;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            stall;
  logic            flush;
  logic            mem_reg_write;
  logic [REGW-1:0] mem_rd;
  logic [XLEN-1:0] mem_result;
  logic            wb_reg_write;
  logic [REGW-1:0] wb_rd;
  logic [XLEN-1:0] wb_result;
  logic            load_use_stall;
  logic            ex_valid;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      ex_alu_control;
  logic [XLEN-1:0] ex_store_data;
  logic [XLEN-1:0] ex_pc;
  logic [REGW-1:0] ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_control, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           stall, flush, mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    input  load_use_stall, ex_valid, alu_a, alu_b, ex_alu_control, ex_store_data,
           ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_control, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           stall, flush, mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    output load_use_stall, ex_valid, alu_a, alu_b, ex_alu_control, ex_store_data,
           ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use bubble
// insertion, stall and flush.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);
  logic            valid_q,     valid_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  logic [REGW-1:0] rs1_q,       rs1_d;
  logic [REGW-1:0] rs2_q,       rs2_d;
  logic [REGW-1:0] rd_q,        rd_d;
  logic [3:0]      alu_ctl_q,   alu_ctl_d;
  logic            alu_src_q,   alu_src_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q,  mem_read_d;
  logic            mem_write_q, mem_write_d;

  logic            load_use_s;
  logic [XLEN-1:0] fwd_a_s;
  logic [XLEN-1:0] fwd_b_s;

  // A load in EX whose destination is read by the instruction in ID forces a bubble.
  assign load_use_s = bus.id_valid & valid_q & mem_read_q & (rd_q != {REGW{1'b0}}) &
                      ((rd_q == bus.id_rs1) | (rd_q == bus.id_rs2));

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    alu_ctl_d   = alu_ctl_q;
    alu_src_d   = alu_src_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (bus.flush || (!bus.stall && load_use_s)) begin
      // Kill or bubble: only the valid/control bits drop, data fields hold.
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (bus.stall) begin
      valid_d     = valid_q;
    end else begin
      valid_d     = bus.id_valid;
      pc_d        = bus.id_pc;
      rs1_data_d  = bus.id_rs1_data;
      rs2_data_d  = bus.id_rs2_data;
      imm_d       = bus.id_imm;
      rs1_d       = bus.id_rs1;
      rs2_d       = bus.id_rs2;
      rd_d        = bus.id_rd;
      alu_ctl_d   = bus.id_alu_control;
      alu_src_d   = bus.id_alu_src;
      reg_write_d = bus.id_reg_write & bus.id_valid;
      mem_read_d  = bus.id_mem_read & bus.id_valid;
      mem_write_d = bus.id_mem_write & bus.id_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= {XLEN{1'b0}};
      rs1_data_q  <= {XLEN{1'b0}};
      rs2_data_q  <= {XLEN{1'b0}};
      imm_q       <= {XLEN{1'b0}};
      rs1_q       <= {REGW{1'b0}};
      rs2_q       <= {REGW{1'b0}};
      rd_q        <= {REGW{1'b0}};
      alu_ctl_q   <= 4'b0000;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_ctl_q   <= alu_ctl_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  always_comb begin
    fwd_a_s = rs1_data_q;
    if (bus.mem_reg_write && (bus.mem_rd != {REGW{1'b0}}) && (bus.mem_rd == rs1_q)) begin
      fwd_a_s = bus.mem_result;
    end else if (bus.wb_reg_write && (bus.wb_rd != {REGW{1'b0}}) && (bus.wb_rd == rs1_q)) begin
      fwd_a_s = bus.wb_result;
    end else begin
      fwd_a_s = rs1_data_q;
    end
  end

  always_comb begin
    fwd_b_s = rs2_data_q;
    if (bus.mem_reg_write && (bus.mem_rd != {REGW{1'b0}}) && (bus.mem_rd == rs2_q)) begin
      fwd_b_s = bus.mem_result;
    end else if (bus.wb_reg_write && (bus.wb_rd != {REGW{1'b0}}) && (bus.wb_rd == rs2_q)) begin
      fwd_b_s = bus.wb_result;
    end else begin
      fwd_b_s = rs2_data_q;
    end
  end

  assign bus.load_use_stall = load_use_s;
  assign bus.ex_valid       = valid_q;
  assign bus.alu_a          = fwd_a_s;
  assign bus.alu_b          = alu_src_q ? imm_q : fwd_b_s;
  assign bus.ex_store_data  = fwd_b_s;
  assign bus.ex_alu_control = alu_ctl_q;
  assign bus.ex_pc          = pc_q;
  assign bus.ex_rd          = rd_q;
  assign bus.ex_reg_write   = reg_write_q;
  assign bus.ex_mem_read    = mem_read_q;
  assign bus.ex_mem_write   = mem_write_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed sequences, a forwarding vector
// table, and randomized traffic against an instruction-level reference model.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  id_ex_stage_if #(.XLEN(32), .REGW(5)) bus ();
  id_ex_stage #(.XLEN(32), .REGW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        mem_we; logic [4:0] mem_rd; logic [31:0] mem_res;
    logic        wb_we;  logic [4:0] wb_rd;  logic [31:0] wb_res;
    logic [31:0] exp_a;  logic [31:0] exp_b;
  } fwd_vec_t;

  // Reference view of the instruction sitting in EX.
  typedef struct {
    logic valid; logic [31:0] pc, d1, d2, imm; logic [4:0] r1, r2, rd;
    logic [3:0] ctl; logic src, rw, mr, mw;
  } slot_t;

  slot_t    m, nxt;
  fwd_vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_valid = 1'b0; bus.id_pc = 32'd0; bus.id_rs1_data = 32'd0; bus.id_rs2_data = 32'd0;
    bus.id_imm = 32'd0; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_rd = 5'd0;
    bus.id_alu_control = 4'd0; bus.id_alu_src = 1'b0; bus.id_reg_write = 1'b0;
    bus.id_mem_read = 1'b0; bus.id_mem_write = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.mem_reg_write = 1'b0; bus.mem_rd = 5'd0; bus.mem_result = 32'd0;
    bus.wb_reg_write = 1'b0; bus.wb_rd = 5'd0; bus.wb_result = 32'd0;
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] own);
    if (idx == 5'd0) return own;
    if (bus.mem_reg_write && bus.mem_rd == idx) return bus.mem_result;
    if (bus.wb_reg_write && bus.wb_rd == idx) return bus.wb_result;
    return own;
  endfunction

  initial begin
    tbl[0] = '{1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22, 32'h11, 32'h2};
    tbl[1] = '{1'b0, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22, 32'h22, 32'h2};
    tbl[2] = '{1'b1, 5'd5, 32'h11, 1'b1, 5'd4, 32'h22, 32'h22, 32'h2};
    tbl[3] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  32'h1,  32'h2};
    tbl[4] = '{1'b1, 5'd7, 32'h11, 1'b1, 5'd4, 32'h22, 32'h22, 32'h11};
    tbl[5] = '{1'b1, 5'd4, 32'h11, 1'b1, 5'd7, 32'h22, 32'h11, 32'h22};
    tbl[6] = '{1'b0, 5'd4, 32'h11, 1'b0, 5'd4, 32'h22, 32'h1,  32'h2};
    tbl[7] = '{1'b1, 5'd7, 32'h33, 1'b1, 5'd7, 32'h44, 32'h1,  32'h33};

    clear_inputs();
    tick(); tick();
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_ctl", 32'(bus.ex_alu_control), 32'd0);
    chk("rst_pc", bus.ex_pc, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    rst = 1'b0;

    // ADD
    bus.id_valid = 1'b1; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2; bus.id_rs1_data = 32'd5;
    bus.id_rs2_data = 32'd7; bus.id_alu_control = 4'b0010; bus.id_rd = 5'd3; bus.id_reg_write = 1'b1;
    tick();
    chk("add_valid", 32'(bus.ex_valid), 32'd1);
    chk("add_a", bus.alu_a, 32'd5);
    chk("add_b", bus.alu_b, 32'd7);
    chk("add_ctl", 32'(bus.ex_alu_control), 32'd2);
    chk("add_rd", 32'(bus.ex_rd), 32'd3);

    // Forwarding table with EX rs1=4 (data 1), rs2=7 (data 2)
    bus.id_rs1 = 5'd4; bus.id_rs1_data = 32'd1; bus.id_rs2 = 5'd7; bus.id_rs2_data = 32'd2;
    tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.mem_reg_write = tbl[i].mem_we; bus.mem_rd = tbl[i].mem_rd; bus.mem_result = tbl[i].mem_res;
      bus.wb_reg_write = tbl[i].wb_we; bus.wb_rd = tbl[i].wb_rd; bus.wb_result = tbl[i].wb_res;
      #1;
      chk($sformatf("fwd%0d_a", i), bus.alu_a, tbl[i].exp_a);
      chk($sformatf("fwd%0d_b", i), bus.alu_b, tbl[i].exp_b);
      chk($sformatf("fwd%0d_sd", i), bus.ex_store_data, tbl[i].exp_b);
    end

    // x0 never forwarded
    clear_inputs();
    bus.id_valid = 1'b1; bus.id_rs1_data = 32'h33; bus.id_rs2_data = 32'h44;
    tick();
    bus.mem_reg_write = 1'b1; bus.mem_result = 32'h55; bus.wb_reg_write = 1'b1; bus.wb_result = 32'h66;
    #1;
    chk("x0_a", bus.alu_a, 32'h33);
    chk("x0_sd", bus.ex_store_data, 32'h44);

    // Load-use bubble
    clear_inputs();
    bus.id_valid = 1'b1; bus.id_mem_read = 1'b1; bus.id_reg_write = 1'b1; bus.id_rd = 5'd6;
    tick();
    chk("ld_in_ex", 32'(bus.ex_mem_read), 32'd1);
    bus.id_mem_read = 1'b0; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd6; bus.id_rd = 5'd8;
    #1;
    chk("lus_set", 32'(bus.load_use_stall), 32'd1);
    tick();
    chk("bub_valid", 32'(bus.ex_valid), 32'd0);
    chk("bub_rw", 32'(bus.ex_reg_write), 32'd0);
    chk("bub_rd_hold", 32'(bus.ex_rd), 32'd6);
    chk("lus_clear", 32'(bus.load_use_stall), 32'd0);

    // Stall holds, then stall+flush kills
    clear_inputs();
    bus.id_valid = 1'b1; bus.id_pc = 32'h100; bus.id_rd = 5'd9; bus.id_alu_control = 4'b0110;
    bus.id_reg_write = 1'b1; bus.id_mem_write = 1'b1;
    tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.id_pc = $urandom; bus.id_rd = 5'($urandom); bus.id_alu_control = 4'($urandom);
      tick();
      chk("stall_pc", bus.ex_pc, 32'h100);
      chk("stall_rd", 32'(bus.ex_rd), 32'd9);
      chk("stall_ctl", 32'(bus.ex_alu_control), 32'd6);
      chk("stall_valid", 32'(bus.ex_valid), 32'd1);
    end
    bus.flush = 1'b1;
    tick();
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_mw", 32'(bus.ex_mem_write), 32'd0);
    chk("flush_pc_hold", bus.ex_pc, 32'h100);

    // Immediate operand vs store data
    clear_inputs();
    bus.id_valid = 1'b1; bus.id_alu_src = 1'b1; bus.id_imm = 32'hFFFF_FFFC; bus.id_rs2 = 5'd8;
    bus.id_rs2_data = 32'd9; bus.id_mem_write = 1'b1; bus.id_pc = 32'h200;
    tick();
    chk("imm_b", bus.alu_b, 32'hFFFF_FFFC);
    chk("imm_sd", bus.ex_store_data, 32'd9);
    chk("imm_mw", 32'(bus.ex_mem_write), 32'd1);

    // Asynchronous reset between edges
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.ex_valid), 32'd0);
    chk("arst_pc", bus.ex_pc, 32'd0);
    chk("arst_mw", 32'(bus.ex_mem_write), 32'd0);
    chk("arst_b", bus.alu_b, 32'd0);
    chk("arst_sd", bus.ex_store_data, 32'd0);
    tick();
    rst = 1'b0;
    m = '{default: '0};

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] exp_b;
      logic        hazard;
      bus.id_valid = 1'($urandom_range(0, 3) != 0); bus.id_pc = $urandom;
      bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom; bus.id_imm = $urandom;
      bus.id_rs1 = 5'($urandom_range(0, 3)); bus.id_rs2 = 5'($urandom_range(0, 3));
      bus.id_rd = 5'($urandom_range(0, 3)); bus.id_alu_control = 4'($urandom);
      bus.id_alu_src = 1'($urandom); bus.id_reg_write = 1'($urandom);
      bus.id_mem_read = 1'($urandom); bus.id_mem_write = 1'($urandom);
      bus.stall = 1'($urandom_range(0, 7) == 0); bus.flush = 1'($urandom_range(0, 7) == 0);
      bus.mem_reg_write = 1'($urandom); bus.mem_rd = 5'($urandom_range(0, 3)); bus.mem_result = $urandom;
      bus.wb_reg_write = 1'($urandom); bus.wb_rd = 5'($urandom_range(0, 3)); bus.wb_result = $urandom;
      #2;
      hazard = bus.id_valid && m.valid && m.mr && m.rd != 5'd0 &&
               (m.rd == bus.id_rs1 || m.rd == bus.id_rs2);
      exp_b = m.src ? m.imm : ref_fwd(m.r2, m.d2);
      chk("rnd_lus", 32'(bus.load_use_stall), 32'(hazard));
      chk("rnd_a", bus.alu_a, ref_fwd(m.r1, m.d1));
      chk("rnd_b", bus.alu_b, exp_b);
      chk("rnd_sd", bus.ex_store_data, ref_fwd(m.r2, m.d2));
      chk("rnd_valid", 32'(bus.ex_valid), 32'(m.valid));
      chk("rnd_pc", bus.ex_pc, m.pc);
      chk("rnd_rd", 32'(bus.ex_rd), 32'(m.rd));
      chk("rnd_ctl", 32'(bus.ex_alu_control), 32'(m.ctl));
      chk("rnd_ctrl", 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}),
          32'({m.rw, m.mr, m.mw}));
      nxt = m;
      if (bus.flush || (!bus.stall && hazard)) begin
        nxt.valid = 1'b0; nxt.rw = 1'b0; nxt.mr = 1'b0; nxt.mw = 1'b0;
      end else if (!bus.stall) begin
        nxt = '{bus.id_valid, bus.id_pc, bus.id_rs1_data, bus.id_rs2_data, bus.id_imm,
                bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_alu_control, bus.id_alu_src,
                bus.id_valid && bus.id_reg_write, bus.id_valid && bus.id_mem_read,
                bus.id_valid && bus.id_mem_write};
      end
      @(posedge clk);
      m = nxt;
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
